// File: rtl/timer_share_arb_pkg.sv
// Shared definitions for the timer-sharing arbiter: FSM encoding and default width.
package timer_share_arb_pkg;

  localparam int unsigned BIT_SZ_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_share_arb_count.sv
// Enable-gated up-counter; the synchronous clear only acts on enabled cycles.
module tmr_count16 #(
  parameter int unsigned BIT_SZ = 16
) (
  input  logic              clock,
  input  logic              en,
  input  logic              clr_n,
  output logic [BIT_SZ-1:0] count
);

  always_ff @(posedge clock) begin
    if (en) begin
      if (!clr_n) count <= '0;
      else        count <= count + BIT_SZ'(1);
    end
  end

endmodule

// File: rtl/timer_share_arb.sv
// Round-robin owner of one shared delay counter; clears, runs and stops it per grant.
module timer_share_arb
  import timer_share_arb_pkg::*;
#(
  parameter int unsigned BIT_SZ = BIT_SZ_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [BIT_SZ-1:0] len0,
  input  logic              req1,
  input  logic [BIT_SZ-1:0] len1,
  input  logic              abort,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic [BIT_SZ-1:0] count_o
);

  state_t            state;
  logic              owner_q;
  logic              last_q;
  logic [BIT_SZ-1:0] len_q;
  logic              winner;
  logic              match;
  logic              stop;
  logic              cnt_en;
  logic              cnt_clr_n;

  // Contention goes to whoever was not served last; last_q resets to 1 so 0 wins first.
  assign winner = (req0 && req1) ? ~last_q : req1;
  assign match  = (count_o == len_q);
  assign stop   = abort || (owner_q ? !req1 : !req0);

  // Enable is forced during reset/clear so the gated clear lands; an abort freezes the count.
  assign cnt_en    = !reset || (state == ST_CLEAR) || ((state == ST_RUN) && !match && !stop);
  assign cnt_clr_n = reset && (state != ST_CLEAR);

  tmr_count16 #(.BIT_SZ(BIT_SZ)) u_count (
    .clock (clock),
    .en    (cnt_en),
    .clr_n (cnt_clr_n),
    .count (count_o)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner_q <= winner;
            len_q   <= winner ? len1 : len0;
            gnt0    <= !winner;
            gnt1    <= winner;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR, ST_RUN: begin
          if (stop) begin
            last_q <= owner_q;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (state == ST_CLEAR) begin
            state <= ST_RUN;
          end else if (match) begin
            done0 <= !owner_q;
            done1 <= owner_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          last_q <= owner_q;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_share_arb.sv
// Directed bench for timer_share_arb with hand-computed cycle-accurate expectations.
module tb_timer_share_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, abort;
  logic [15:0] len0, len1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] count_o;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  timer_share_arb #(.BIT_SZ(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .len0    (len0),
    .req1    (req1),
    .len1    (len1),
    .abort   (abort),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .busy    (busy),
    .count_o (count_o)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gnt0,gnt1,done0,done1,busy packed for compact checks
  function automatic logic [4:0] outs();
    return {gnt0, gnt1, done0, done1, busy};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_count", 32'(count_o), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; abort = 1'b0; len0 = '0; len1 = '0;
    #1;
    do_reset();

    // Single request, len=5; len0 change mid-run must not matter
    req0 = 1'b1; len0 = 16'd5;
    tick();
    chk("t1_c1_outs", 32'(outs()), 32'b10001);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk("t1_count", 32'(count_o), 32'(c - 2));
      chk("t1_nodone", 32'(done0), 32'h0);
      if (c == 3) len0 = 16'd9;
    end
    tick();
    chk("t1_c8_outs", 32'(outs()), 32'b10101);
    chk("t1_c8_count", 32'(count_o), 32'd5);
    req0 = 1'b0;
    tick();
    chk("t1_c9_outs", 32'(outs()), 32'b00000);
    chk("t1_c9_hold", 32'(count_o), 32'd5);

    // Contention right after reset: 0 first, then 1
    do_reset();
    req0 = 1'b1; req1 = 1'b1; len0 = 16'd2; len1 = 16'd3;
    tick();
    chk("t2_c1_outs", 32'(outs()), 32'b10001);
    repeat (4) tick();
    chk("t2_c5_outs", 32'(outs()), 32'b10101);
    chk("t2_c5_count", 32'(count_o), 32'd2);
    req0 = 1'b0;
    tick();
    chk("t2_c6_idle", 32'(outs()), 32'b00000);
    tick();
    chk("t2_c7_outs", 32'(outs()), 32'b01001);
    repeat (4) tick();
    chk("t2_c11_nodone", 32'(done1), 32'h0);
    tick();
    chk("t2_c12_outs", 32'(outs()), 32'b01011);
    chk("t2_c12_count", 32'(count_o), 32'd3);
    req1 = 1'b0;
    tick();
    chk("t2_c13_outs", 32'(outs()), 32'b00000);

    // len=0
    req0 = 1'b1; len0 = 16'd0;
    tick(); tick();
    chk("t3_c2_count", 32'(count_o), 32'd0);
    chk("t3_c2_nodone", 32'(done0), 32'h0);
    tick();
    chk("t3_c3_outs", 32'(outs()), 32'b10101);
    chk("t3_c3_count", 32'(count_o), 32'd0);
    req0 = 1'b0;
    tick();

    // Abort requester 1 at count 4: count holds, no done
    req1 = 1'b1; len1 = 16'd10;
    repeat (6) tick();
    chk("t4_c6_count", 32'(count_o), 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_c7_outs", 32'(outs()), 32'b00000);
    chk("t4_c7_hold", 32'(count_o), 32'd4);
    req1 = 1'b0;
    repeat (3) tick();
    chk("t4_later_outs", 32'(outs()), 32'b00000);

    // Pointer advanced on abort: contention now goes to 0; req drop aborts
    req0 = 1'b1; req1 = 1'b1; len0 = 16'd1; len1 = 16'd1;
    tick();
    chk("t5_c1_outs", 32'(outs()), 32'b10001);
    tick();
    req0 = 1'b0;
    tick();
    chk("t5_c3_outs", 32'(outs()), 32'b00000);
    tick();
    chk("t5_c4_outs", 32'(outs()), 32'b01001);
    req1 = 1'b0;
    tick();
    chk("t5_c5_outs", 32'(outs()), 32'b00000);

    // Abort coinciding with match: no done
    req0 = 1'b1; len0 = 16'd3;
    repeat (5) tick();
    chk("t6_c5_count", 32'(count_o), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_c6_outs", 32'(outs()), 32'b00000);
    req0 = 1'b0;
    tick();

    // Reset mid-run at count 7
    req0 = 1'b1; len0 = 16'd20;
    repeat (9) tick();
    chk("t7_c9_count", 32'(count_o), 32'd7);
    reset = 1'b0;
    tick();
    chk("t7_rst_outs", 32'(outs()), 32'b00000);
    chk("t7_rst_count", 32'(count_o), 32'd0);
    reset = 1'b1; req0 = 1'b0;
    tick();
    chk("t7_after_outs", 32'(outs()), 32'b00000);

    // Maximum length: reaches FFFF, no wrap
    req0 = 1'b1; len0 = 16'hFFFF;
    tick();
    chk("t8_c1_outs", 32'(outs()), 32'b10001);
    for (int c = 2; c <= 65537; c++) tick();
    chk("t8_c65537_count", 32'(count_o), 32'hFFFF);
    chk("t8_c65537_nodone", 32'(done0), 32'h0);
    tick();
    chk("t8_c65538_outs", 32'(outs()), 32'b10101);
    chk("t8_c65538_count", 32'(count_o), 32'hFFFF);
    req0 = 1'b0;
    tick();
    chk("t8_end_outs", 32'(outs()), 32'b00000);
    chk("t8_end_count", 32'(count_o), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
